part_xchg_init_bridge: RTL

Parametrised initiator-side partition exchange engine for split-simulation co-sim. On each rising edge of a channel's mission clock, it snapshots that channel's packed partition signals and ships them to the target over a shared valid/ready transmit port. It then waits for the target's reply vector, holding that channel's clock frozen until the reply arrives. It sits between the partition's boundary signals and the transport adaptor, and generalises the single-event initiator to N independent channels with a watchdog, early-arrival buffering and error reporting.

---
 rtl/part_xchg_init_bridge.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/part_xchg_init_bridge.sv
// -----------------------------------------------------------------------------
// part_xchg_init_bridge
//
// Initiator-side partition exchange engine for split-simulation co-sim.
// Each of N_CH channels follows one mission clock. On a rising mission edge
// the channel snapshots its slice of the partition outputs and ships it to
// the target through a shared, round-robin arbitrated valid/ready transmit
// slot. If the channel expects a reply, its mission clock is frozen until the
// reply arrives or a watchdog expires. Replies that arrive early are parked
// in a one-deep pending slot per channel and delivered on the next edge.
//
// Ports
//   clk_i         utility clock, all logic on its rising edge
//   rst_i         asynchronous, active-high reset
//   mclk_i        mission clocks (one per channel), sampled by clk_i
//   put_en_i      channel sends a vector on each mission edge
//   get_en_i      channel waits for a reply after each mission edge
//   sut_data_i    packed partition outputs, channel c at [c*DW +: DW]
//   tx_valid_o    transmit word valid
//   tx_ready_i    transport accepts the transmit word
//   tx_ch_o       channel of the transmit word
//   tx_data_o     transmit payload
//   rx_valid_i    reply word present (always accepted)
//   rx_ch_i       reply channel; values >= N_CH are ignored
//   rx_data_i     reply payload
//   rcv_data_o    last reply delivered per channel
//   rcv_valid_o   one-cycle pulse per delivered reply
//   freeze_clk_o  hold the channel's mission clock generator
//   err_o         sticky: [0] watchdog timeout, [1] rx overrun,
//                 [2] missed mission edge
//   err_ch_o      channel of the first error recorded since reset
// -----------------------------------------------------------------------------
module part_xchg_init_bridge #(
    parameter int N_CH     = 4,
    parameter int DW       = 9,
    parameter int WD_LIMIT = 10000,
    parameter int CW       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N_CH-1:0]      mclk_i,
    input  logic [N_CH-1:0]      put_en_i,
    input  logic [N_CH-1:0]      get_en_i,
    input  logic [N_CH*DW-1:0]   sut_data_i,
    output logic                 tx_valid_o,
    input  logic                 tx_ready_i,
    output logic [CW-1:0]        tx_ch_o,
    output logic [DW-1:0]        tx_data_o,
    input  logic                 rx_valid_i,
    input  logic [CW-1:0]        rx_ch_i,
    input  logic [DW-1:0]        rx_data_i,
    output logic [N_CH*DW-1:0]   rcv_data_o,
    output logic [N_CH-1:0]      rcv_valid_o,
    output logic [N_CH-1:0]      freeze_clk_o,
    output logic [2:0]           err_o,
    output logic [CW-1:0]        err_ch_o
);

    localparam int WDW = $clog2(WD_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        SENT,
        WAIT_RX
    } ch_state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    ch_state_t          st        [N_CH];
    logic [DW-1:0]      snap      [N_CH];
    logic [DW-1:0]      pend_data [N_CH];
    logic [WDW-1:0]     wd_cnt    [N_CH];
    logic [N_CH-1:0]    pend_valid;
    logic [N_CH-1:0]    mclk_q;
    logic [N_CH-1:0]    edge_q;
    logic [CW-1:0]      rr_ptr;

    // -------------------------------------------------------------------------
    // Per-cycle decisions
    // -------------------------------------------------------------------------
    logic               tx_free;
    logic               gnt_valid;
    logic [CW-1:0]      gnt_idx;
    logic [N_CH-1:0]    rx_hit;     // reply addressed to this channel
    logic [N_CH-1:0]    hs;         // this channel's word handshakes now
    logic [N_CH-1:0]    avail;      // a reply word is on hand this cycle
    logic [N_CH-1:0]    take;       // channel consumes a reply if one is on hand
    logic [N_CH-1:0]    wd_expire;
    logic [N_CH-1:0]    ev_ovr;
    logic [N_CH-1:0]    ev_miss;
    logic [DW-1:0]      take_data [N_CH];
    logic [2:0]         err_new;
    logic [CW-1:0]      err_new_ch;

    // The slot may reload in the same cycle its current word is accepted,
    // which gives back-to-back words at full rate.
    assign tx_free = ~tx_valid_o | tx_ready_i;

    // Round-robin grant: lowest SEND channel at or above rr_ptr, wrapping.
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise a latch is inferred.
    always_comb begin : arbiter
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int i = 0; i < N_CH; i++) begin
            int idx;
            idx = (int'(rr_ptr) + i) % N_CH;
            if (!gnt_valid && st[idx] == SEND) begin
                gnt_valid = 1'b1;
                gnt_idx   = CW'(idx);
            end
        end
    end

    always_comb begin : channel_events
        for (int c = 0; c < N_CH; c++) begin
            // Comparing against in-range indices only drops rx_ch_i >= N_CH.
            rx_hit[c]    = rx_valid_i && (rx_ch_i == CW'(c));
            hs[c]        = tx_valid_o && tx_ready_i && (tx_ch_o == CW'(c));
            avail[c]     = pend_valid[c] | rx_hit[c];
            // The older parked word is delivered first; a same-cycle arrival
            // then takes its place in the pending slot.
            take_data[c] = pend_valid[c] ? pend_data[c] : rx_data_i;
            take[c]      = ((st[c] == IDLE) && edge_q[c] && !put_en_i[c] && get_en_i[c])
                        || ((st[c] == SENT) && hs[c] && get_en_i[c])
                        || (st[c] == WAIT_RX);
            wd_expire[c] = (st[c] == WAIT_RX) && !avail[c]
                        && (wd_cnt[c] == WDW'(WD_LIMIT - 1));
            ev_ovr[c]    = rx_hit[c] && pend_valid[c] && !take[c];
            ev_miss[c]   = edge_q[c] && (st[c] != IDLE);
        end
    end

    // Descending scan so the lowest erroring channel is the one recorded.
    always_comb begin : error_events
        err_new    = {|ev_miss, |ev_ovr, |wd_expire};
        err_new_ch = '0;
        for (int c = N_CH - 1; c >= 0; c--) begin
            if (ev_miss[c] || ev_ovr[c] || wd_expire[c]) begin
                err_new_ch = CW'(c);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Sequential: edge detect, transmit slot, channel FSMs, error capture
    // NOTE: state is written with non-blocking assignments only, so every
    // read in this block sees the value from before the clock edge.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mclk_q       <= '0;
            edge_q       <= '0;
            rr_ptr       <= '0;
            pend_valid   <= '0;
            tx_valid_o   <= 1'b0;
            tx_ch_o      <= '0;
            tx_data_o    <= '0;
            rcv_data_o   <= '0;
            rcv_valid_o  <= '0;
            freeze_clk_o <= '0;
            err_o        <= '0;
            err_ch_o     <= '0;
            // NOTE: the per-channel arrays are tiny and their contents reach
            // outputs, so they are reset like any other register.
            for (int c = 0; c < N_CH; c++) begin
                st[c]        <= IDLE;
                snap[c]      <= '0;
                pend_data[c] <= '0;
                wd_cnt[c]    <= '0;
            end
        end else begin
            mclk_q      <= mclk_i;
            edge_q      <= mclk_i & ~mclk_q;
            rcv_valid_o <= '0;

            // Transmit slot holds its contents while stalled.
            if (tx_free) begin
                tx_valid_o <= gnt_valid;
                if (gnt_valid) begin
                    tx_ch_o   <= gnt_idx;
                    tx_data_o <= snap[gnt_idx];
                    rr_ptr    <= (gnt_idx == CW'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
                end
            end

            for (int c = 0; c < N_CH; c++) begin
                freeze_clk_o[c] <= 1'b0;

                // Reply bookkeeping: deliver if the channel is consuming,
                // otherwise park the word (overwriting flags an overrun).
                if (take[c] && avail[c]) begin
                    rcv_data_o[c*DW +: DW] <= take_data[c];
                    rcv_valid_o[c]         <= 1'b1;
                    pend_valid[c]          <= pend_valid[c] & rx_hit[c];
                    if (pend_valid[c] && rx_hit[c]) begin
                        pend_data[c] <= rx_data_i;
                    end
                end else if (rx_hit[c]) begin
                    pend_valid[c] <= 1'b1;
                    pend_data[c]  <= rx_data_i;
                end

                unique case (st[c])
                    IDLE: begin
                        // With a reply already parked, get-only delivers at
                        // once and the mission clock is never frozen.
                        if (edge_q[c]) begin
                            if (put_en_i[c]) begin
                                st[c]   <= SEND;
                                snap[c] <= sut_data_i[c*DW +: DW];
                            end else if (get_en_i[c] && !avail[c]) begin
                                st[c]           <= WAIT_RX;
                                wd_cnt[c]       <= '0;
                                freeze_clk_o[c] <= 1'b1;
                            end
                        end
                    end
                    SEND: begin
                        if (tx_free && gnt_valid && gnt_idx == CW'(c)) begin
                            st[c] <= SENT;
                        end
                    end
                    SENT: begin
                        if (hs[c]) begin
                            if (get_en_i[c] && !avail[c]) begin
                                st[c]           <= WAIT_RX;
                                wd_cnt[c]       <= '0;
                                freeze_clk_o[c] <= 1'b1;
                            end else begin
                                st[c] <= IDLE;
                            end
                        end
                    end
                    WAIT_RX: begin
                        if (avail[c] || wd_expire[c]) begin
                            st[c]     <= IDLE;
                            wd_cnt[c] <= '0;
                        end else begin
                            wd_cnt[c]       <= wd_cnt[c] + 1'b1;
                            freeze_clk_o[c] <= 1'b1;
                        end
                    end
                endcase
            end

            err_o <= err_o | err_new;
            if (err_o == '0 && err_new != '0) begin
                err_ch_o <= err_new_ch;
            end
        end
    end

endmodule
